// File: rtl/soi_pkg.sv
// soi_pkg: shared types for the SOI injection path.
//   inj_op_e     - command opcode (SET/CLR/TGL/REL)
//   inj_state_e  - scheduler state
//   applyOp()    - next {en,val} of one override bank slot for a given op
package soi_pkg;

  typedef enum logic [1:0] {
    SET = 2'd0,
    CLR = 2'd1,
    TGL = 2'd2,
    REL = 2'd3
  } inj_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } inj_state_e;

  // Returns {newEn, newVal}. REL drops the override but keeps the last value
  // so a later TGL continues from where the signal was left.
  function automatic logic [1:0] applyOp(input inj_op_e op, input logic en, input logic val);
    logic [1:0] res;
    res = {en, val};
    case (op)
      SET:     res = 2'b11;
      CLR:     res = 2'b10;
      TGL:     res = {1'b1, ~val};
      REL:     res = {1'b0, val};
      default: res = {en, val};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/soi_cmd_fifo.sv
// soi_cmd_fifo: synchronous FIFO holding queued injection commands.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push_i, wdata_i   - write request and data (ignored when full)
//   pop_i             - read request (ignored when empty)
//   rdata_o           - head entry (valid when !empty_o)
//   level_o           - occupied entries, 0..DEPTH
//   full_o, empty_o   - registered status flags
module soi_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             doPush, doPop;

  assign doPush = push_i && !full_q;
  assign doPop  = pop_i && !empty_q;

  // Simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + LVL_W'(1);
    end else if (doPop && !doPush) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Storage is not reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/soi_injector.sv
// soi_injector: applies host-queued, timed injection commands to a bank of
// per-signal override enables/values. Downstream logic muxes inj_val over
// its native signal wherever inj_en is set.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   cmd_valid/cmd_ready         - command handshake (ready = FIFO not full)
//   cmd_idx, cmd_op, cmd_cycle  - target signal, opcode, absolute apply cycle
//   inj_en, inj_val             - override bank
//   cycle_cnt                   - free-running cycle counter
//   ack_valid, ack_idx, ack_late- one-cycle apply acknowledge
//   fifo_level                  - queued command count
// Optional build macro SOI_INJ_TRACE_EN: prints each applied command.
module soi_injector
  import soi_pkg::*;
#(
  parameter int NUM_SIG = 8,
  parameter int DEPTH   = 4,
  parameter int CYC_W   = 32,
  localparam int IDX_W  = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [1:0]         cmd_op,
  input  logic [CYC_W-1:0]   cmd_cycle,
  output logic [NUM_SIG-1:0] inj_en,
  output logic [NUM_SIG-1:0] inj_val,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic               ack_valid,
  output logic [IDX_W-1:0]   ack_idx,
  output logic               ack_late,
  output logic [LVL_W-1:0]   fifo_level
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    inj_op_e          op;
    logic [CYC_W-1:0] cycle;
  } inj_cmd_t;

  localparam int CMD_W = $bits(inj_cmd_t);

  inj_state_e         state_q;
  logic [CYC_W-1:0]   cycleCnt_q;
  logic [NUM_SIG-1:0] bankEn_q, bankVal_q;
  logic               ackValid_q, ackLate_q;
  logic [IDX_W-1:0]   ackIdx_q;

  inj_cmd_t           newCmd, headCmd;
  logic [CMD_W-1:0]   fifoRdata;
  logic [LVL_W-1:0]   fifoLevel;
  logic               fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CYC_W-1:0]   cycDiff;
  logic               headLate, headDue, idxInRange;
  logic [1:0]         opRes;

  always_comb begin
    newCmd       = '0;
    newCmd.idx   = cmd_idx;
    newCmd.op    = inj_op_e'(cmd_op);
    newCmd.cycle = cmd_cycle;
  end

  assign fifoPush = cmd_valid && !fifoFull;
  assign fifoPop  = (state_q == APPLY);

  soi_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .wdata_i (newCmd),
    .pop_i   (fifoPop),
    .rdata_o (fifoRdata),
    .level_o (fifoLevel),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign headCmd = inj_cmd_t'(fifoRdata);

  // Lateness is the sign of the wrapped difference, so a target slightly
  // behind the counter is late while one ahead (even across wrap) waits.
  assign cycDiff    = cycleCnt_q - headCmd.cycle;
  assign headLate   = !cycDiff[CYC_W-1] && (cycDiff != '0);
  assign headDue    = (cycDiff == '0) || headLate;
  assign idxInRange = int'(headCmd.idx) < NUM_SIG;
  assign opRes      = applyOp(headCmd.op, bankEn_q[headCmd.idx], bankVal_q[headCmd.idx]);

  // Scheduler. IDLE evaluates a freshly visible head straight away (same
  // compare as WAIT) so an already-due command is acked two cycles after
  // its push. The bank and ack register on entry to APPLY; the pop happens
  // on the edge leaving APPLY, giving one command per two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      bankEn_q   <= '0;
      bankVal_q  <= '0;
      ackValid_q <= 1'b0;
      ackIdx_q   <= '0;
      ackLate_q  <= 1'b0;
    end else begin
      cycleCnt_q <= cycleCnt_q + CYC_W'(1);
      ackValid_q <= 1'b0;
      case (state_q)
        IDLE, WAIT: begin
          if (fifoEmpty) begin
            state_q <= IDLE;
          end else if (headDue) begin
            state_q    <= APPLY;
            ackValid_q <= 1'b1;
            ackIdx_q   <= headCmd.idx;
            ackLate_q  <= headLate;
            if (idxInRange) begin
              bankEn_q[headCmd.idx]  <= opRes[1];
              bankVal_q[headCmd.idx] <= opRes[0];
            end
`ifdef SOI_INJ_TRACE_EN
            $display("[soi_injector] cyc=%0d idx=%0d op=%s val=%0b%s",
                     cycleCnt_q, headCmd.idx, headCmd.op.name(), opRes[0],
                     headLate ? " LATE" : "");
`endif
          end else begin
            state_q <= WAIT;
          end
        end
        APPLY: begin
          state_q <= ((fifoLevel > LVL_W'(1)) || fifoPush) ? WAIT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifoFull;
  assign inj_en     = bankEn_q;
  assign inj_val    = bankVal_q;
  assign cycle_cnt  = cycleCnt_q;
  assign ack_valid  = ackValid_q;
  assign ack_idx    = ackIdx_q;
  assign ack_late   = ackLate_q;
  assign fifo_level = fifoLevel;

endmodule

// File: tb/tb_soi_injector.sv
// tb_soi_injector: self-checking bench for soi_injector, built with an 8-bit
// cycle counter so counter wrap is reachable quickly. A queue-based model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_soi_injector;

  localparam int NUM_SIG = 8;
  localparam int DEPTH   = 4;
  localparam int CYC_W   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_idx = '0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_cycle = '0;
  logic       cmd_ready;
  logic [7:0] inj_en, inj_val, cycle_cnt;
  logic       ack_valid, ack_late;
  logic [2:0] ack_idx;
  logic [2:0] fifo_level;

  soi_injector #(
    .NUM_SIG (NUM_SIG),
    .DEPTH   (DEPTH),
    .CYC_W   (CYC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_idx    (cmd_idx),
    .cmd_op     (cmd_op),
    .cmd_cycle  (cmd_cycle),
    .inj_en     (inj_en),
    .inj_val    (inj_val),
    .cycle_cnt  (cycle_cnt),
    .ack_valid  (ack_valid),
    .ack_idx    (ack_idx),
    .ack_late   (ack_late),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a queue of pending commands, checked against the
  // wrapped counter; one command per two cycles, strictly in order.
  typedef struct {
    int idx;
    int op;
    int cyc;
  } mcmd_t;

  mcmd_t      mQ[$];
  int         tbCycle = 0;
  int         mCnt = 0;
  logic [7:0] mEn = '0, mVal = '0;
  bit         mAckV = 0, mAckLate = 0, mReady = 1;
  int         mAckIdx = 0;
  bit         modelValid = 0;
  bit         lastAccepted = 0;
  int         lastAcceptCycle = -1;

  always @(posedge clk) begin : modelTick
    mcmd_t head;
    int    d;
    bit    newAck;
    lastAccepted = 0;
    if (rst) begin
      mQ.delete();
      tbCycle = 0; mCnt = 0; mEn = '0; mVal = '0;
      mAckV = 0; mAckLate = 0; mAckIdx = 0; mReady = 1;
      modelValid = 1;
    end else if (modelValid) begin
      newAck = 0;
      if (mAckV) begin
        void'(mQ.pop_front());
      end else if (mQ.size() > 0) begin
        head = mQ[0];
        d = (mCnt - head.cyc) & 255;
        if (d <= 127) begin
          newAck = 1;
          mAckIdx = head.idx;
          mAckLate = (d != 0);
          case (head.op)
            0: begin mEn[head.idx] = 1'b1; mVal[head.idx] = 1'b1; end
            1: begin mEn[head.idx] = 1'b1; mVal[head.idx] = 1'b0; end
            2: begin mEn[head.idx] = 1'b1; mVal[head.idx] = ~mVal[head.idx]; end
            default: mEn[head.idx] = 1'b0;
          endcase
        end
      end
      if (cmd_valid && mReady) begin
        mQ.push_back('{int'(cmd_idx), int'(cmd_op), int'(cmd_cycle)});
        lastAccepted = 1;
        lastAcceptCycle = tbCycle;
      end
      mReady = (mQ.size() < DEPTH);
      mCnt = (mCnt + 1) & 255;
      tbCycle++;
      mAckV = newAck;
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cycle_cnt", 32'(cycle_cnt), 32'(mCnt));
      checkOutput("inj_en", 32'(inj_en), 32'(mEn));
      checkOutput("inj_val", 32'(inj_val), 32'(mVal));
      checkOutput("ack_valid", 32'(ack_valid), 32'(mAckV));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(mReady));
      checkOutput("fifo_level", 32'(fifo_level), 32'(mQ.size()));
      if (mAckV) begin
        checkOutput("ack_idx", 32'(ack_idx), 32'(mAckIdx));
        checkOutput("ack_late", 32'(ack_late), 32'(mAckLate));
      end
    end
  end

  // Offer one command and hold it until the handshake completes.
  task automatic applyStimulus(input int idx, input int op, input int cyc);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_idx   = 3'(idx);
    cmd_op    = 2'(op);
    cmd_cycle = 8'(cyc);
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!lastAccepted && guard < 500);
    if (!lastAccepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL push_timeout: got no accept, expected accept within 500 cycles");
    end
    cmd_valid = 1'b0;
  endtask

  task automatic gotoCycle(input int n);
    int guard = 0;
    while (tbCycle != n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (tbCycle != n) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL goto_cycle: got cycle %0d, expected %0d", tbCycle, n);
    end
  endtask

  task automatic checkAt(input int n);
    gotoCycle(n);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("rst_inj_en", 32'(inj_en), 32'd0);
    checkOutput("rst_inj_val", 32'(inj_val), 32'd0);
    checkOutput("rst_ack_valid", 32'(ack_valid), 32'd0);
    checkOutput("rst_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // On-time SET: pushed at 2 for cycle 10, visible in 11.
    gotoCycle(2);
    applyStimulus(3, 0, 10);
    checkAt(10);
    checkOutput("s1_no_early_ack", 32'(ack_valid), 32'd0);
    checkAt(11);
    checkOutput("s1_ack", 32'(ack_valid), 32'd1);
    checkOutput("s1_ack_idx", 32'(ack_idx), 32'd3);
    checkOutput("s1_ack_late", 32'(ack_late), 32'd0);
    checkOutput("s1_inj_en", 32'(inj_en), 32'h08);
    checkOutput("s1_inj_val", 32'(inj_val), 32'h08);

    // Same-index sequence: SET@20, TGL@20 (late), REL@30.
    gotoCycle(12);
    applyStimulus(5, 0, 20);
    applyStimulus(5, 2, 20);
    applyStimulus(5, 3, 30);
    checkAt(21);
    checkOutput("s2_set_ack", 32'(ack_valid), 32'd1);
    checkOutput("s2_set_late", 32'(ack_late), 32'd0);
    checkOutput("s2_set_val5", 32'(inj_val[5]), 32'd1);
    checkAt(23);
    checkOutput("s2_tgl_ack", 32'(ack_valid), 32'd1);
    checkOutput("s2_tgl_late", 32'(ack_late), 32'd1);
    checkOutput("s2_tgl_val5", 32'(inj_val[5]), 32'd0);
    checkAt(31);
    checkOutput("s2_rel_ack", 32'(ack_valid), 32'd1);
    checkOutput("s2_rel_en5", 32'(inj_en[5]), 32'd0);

    // Fill the FIFO with far-future commands; the fifth waits for a pop.
    gotoCycle(40);
    applyStimulus(0, 0, 140);
    applyStimulus(1, 0, 140);
    applyStimulus(4, 0, 140);
    applyStimulus(6, 0, 140);
    @(negedge clk);
    checkOutput("s3_level_full", 32'(fifo_level), 32'd4);
    checkOutput("s3_ready_low", 32'(cmd_ready), 32'd0);
    fork
      applyStimulus(7, 0, 140);
      begin
        checkAt(141);
        checkOutput("s3_first_ack", 32'(ack_valid), 32'd1);
        checkOutput("s3_first_idx", 32'(ack_idx), 32'd0);
        checkOutput("s3_first_late", 32'(ack_late), 32'd0);
      end
    join
    checkOutput("s3_fifth_accept_cycle", 32'(lastAcceptCycle), 32'd142);

    // Already-past target: pushed at 150, acked late at 152.
    gotoCycle(150);
    applyStimulus(2, 0, 105);
    checkAt(152);
    checkOutput("s4_ack", 32'(ack_valid), 32'd1);
    checkOutput("s4_late", 32'(ack_late), 32'd1);
    checkOutput("s4_val2", 32'(inj_val[2]), 32'd1);

    // Target = push+1 is exact, not late.
    gotoCycle(160);
    applyStimulus(3, 1, 161);
    checkAt(162);
    checkOutput("s5_ack", 32'(ack_valid), 32'd1);
    checkOutput("s5_late", 32'(ack_late), 32'd0);
    checkOutput("s5_en3", 32'(inj_en[3]), 32'd1);
    checkOutput("s5_val3", 32'(inj_val[3]), 32'd0);

    // Counter wrap: pushed at count 250 for count 3, acked at count 4.
    gotoCycle(250);
    applyStimulus(6, 2, 3);
    checkAt(259);
    checkOutput("s6_no_early_ack", 32'(ack_valid), 32'd0);
    checkAt(260);
    checkOutput("s6_ack", 32'(ack_valid), 32'd1);
    checkOutput("s6_late", 32'(ack_late), 32'd0);
    checkOutput("s6_idx", 32'(ack_idx), 32'd6);
    checkOutput("s6_cnt", 32'(cycle_cnt), 32'd4);
    checkAt(261);
    checkOutput("s6_bank_en", 32'(inj_en), 32'hDF);
    checkOutput("s6_bank_val", 32'(inj_val), 32'h97);

    // Reset while commands are waiting.
    gotoCycle(270);
    applyStimulus(0, 1, 114);
    applyStimulus(1, 1, 114);
    applyStimulus(2, 1, 114);
    @(negedge clk);
    checkOutput("s7_level_before", 32'(fifo_level), 32'd3);
    gotoCycle(274);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("s7_cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("s7_level", 32'(fifo_level), 32'd0);
    checkOutput("s7_en", 32'(inj_en), 32'd0);
    checkOutput("s7_ack", 32'(ack_valid), 32'd0);
    checkOutput("s7_ready", 32'(cmd_ready), 32'd1);

    // Randomised traffic with targets from 20 cycles past to 40 ahead.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      (mCnt + 236 + int'($urandom_range(0, 60))) & 255);
      end
    end

    guard = 0;
    while ((mQ.size() > 0 || mAckV) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: got %0d queued, expected 0", mQ.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
